// File: rtl/spike_packet_dispatcher_pkg.sv
// rtl/spike_packet_dispatcher_pkg.sv - shared defaults and FSM encoding for the spike packet dispatcher
package spike_packet_dispatcher_pkg;

   localparam int DEF_NUM_NEURONS = 10;
   localparam int DEF_ADDR_W      = 12;
   localparam int DEF_MAX_CONN    = 32;
   localparam int DEF_PTR_W       = 6;
   localparam int DEF_FIFO_DEPTH  = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_EMIT = 2'd2
   } disp_state_t;

endpackage

// File: rtl/spike_packet_fifo.sv
// rtl/spike_packet_fifo.sv - show-ahead packet FIFO with a registered head; capacity counts the head slot
module spike_packet_fifo
   import spike_packet_dispatcher_pkg::*;
#(
   parameter int WIDTH = 2 * DEF_ADDR_W,
   parameter int DEPTH = DEF_FIFO_DEPTH
) (
   input  logic             CLK,
   input  logic             RESET_N,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             head_valid,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [CW-1:0]    count;
   logic [CW-1:0]    level;
   logic             do_push, do_load;

   assign level   = count + CW'(head_valid);
   assign full    = (level == CW'(DEPTH));
   assign empty   = (level == '0);
   assign do_push = push && (!full || pop);
   // Writes always land in storage first, so the head appears one cycle after the push.
   assign do_load = (!head_valid || pop) && (count != '0);

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         head       <= '0;
         head_valid <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_load) begin
            head   <= mem[rd_ptr];
            rd_ptr <= rd_ptr + AW'(1);
         end
         if (do_load)  head_valid <= 1'b1;
         else if (pop) head_valid <= 1'b0;
         count <= count + CW'(do_push) - CW'(do_load);
      end
   end

endmodule

// File: rtl/spike_packet_dispatcher.sv
// rtl/spike_packet_dispatcher.sv - collects spikes per timestep and emits {origin,dest} packets from a CSR fan-out table
module spike_packet_dispatcher
   import spike_packet_dispatcher_pkg::*;
#(
   parameter int NUM_NEURONS = DEF_NUM_NEURONS,
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int MAX_CONN    = DEF_MAX_CONN,
   parameter int PTR_W       = DEF_PTR_W,
   parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
   input  logic                           CLK,
   input  logic                           RESET_N,
   input  logic                           clear,
   input  logic [NUM_NEURONS-1:0]         spikes,
   input  logic                           init_load,
   input  logic [NUM_NEURONS*ADDR_W-1:0]  neuron_addresses_initialization,
   input  logic [(NUM_NEURONS+1)*PTR_W-1:0] connection_pointer_initialization,
   input  logic [MAX_CONN*ADDR_W-1:0]     downstream_connections_initialization,
   output logic [2*ADDR_W-1:0]            packet,
   output logic                           packet_valid,
   input  logic                           packet_ready,
   output logic                           busy,
   output logic                           overrun,
   output logic                           table_error
);

   localparam int IDX_W  = $clog2(NUM_NEURONS + 1);
   localparam int CONN_W = $clog2(MAX_CONN);

   logic [ADDR_W-1:0]      naddr [NUM_NEURONS];
   logic [PTR_W-1:0]       ptr   [NUM_NEURONS+1];
   logic [ADDR_W-1:0]      dconn [MAX_CONN];
   logic [NUM_NEURONS-1:0] pending, work, snapshot, done_mask;
   disp_state_t            state;
   logic [IDX_W-1:0]       idx, scan_idx;
   logic [PTR_W-1:0]       cur, end_ptr, scan_cur, scan_end;
   logic                   scan_go, table_bad;
   logic                   fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [2*ADDR_W-1:0]    push_data;

   function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_NEURONS-1:0] v);
      lowest_set = '0;
      for (int i = NUM_NEURONS - 1; i >= 0; i--)
         if (v[i]) lowest_set = IDX_W'(i);
   endfunction

   // Spikes present in the clear cycle still belong to the timestep that is closing.
   assign snapshot  = pending | spikes;
   assign scan_idx  = lowest_set(work);
   assign scan_cur  = ptr[scan_idx];
   assign scan_end  = ptr[scan_idx + IDX_W'(1)];
   assign fifo_push = (state == ST_EMIT) && !fifo_full;
   assign fifo_pop  = packet_valid && packet_ready;
   assign push_data = {naddr[idx], dconn[cur[CONN_W-1:0]]};
   assign busy      = (state != ST_IDLE) || !fifo_empty;

   always_comb begin
      done_mask = '0;
      scan_go   = 1'b0;
      table_bad = 1'b0;
      if (state == ST_SCAN && work != '0) begin
         if (scan_end <= scan_cur) begin
            done_mask[scan_idx] = 1'b1;
         end else if (scan_end > PTR_W'(MAX_CONN)) begin
            done_mask[scan_idx] = 1'b1;
            table_bad           = 1'b1;
         end else begin
            scan_go = 1'b1;
         end
      end else if (fifo_push && cur == end_ptr - PTR_W'(1)) begin
         done_mask[idx] = 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state       <= ST_IDLE;
         idx         <= '0;
         cur         <= '0;
         end_ptr     <= '0;
         pending     <= '0;
         work        <= '0;
         overrun     <= 1'b0;
         table_error <= 1'b0;
         for (int i = 0; i < NUM_NEURONS; i++)     naddr[i] <= '0;
         for (int i = 0; i < NUM_NEURONS + 1; i++) ptr[i]   <= '0;
         for (int i = 0; i < MAX_CONN; i++)        dconn[i] <= '0;
      end else begin
         pending <= clear ? '0 : (pending | spikes);
         // A clear during a pass merges its snapshot so nothing is dropped.
         work    <= (work & ~done_mask) | (clear ? snapshot : '0);
         if (clear && state != ST_IDLE) overrun <= 1'b1;
         if (table_bad) table_error <= 1'b1;

         if (init_load && state == ST_IDLE && fifo_empty) begin
            for (int i = 0; i < NUM_NEURONS; i++)
               naddr[i] <= neuron_addresses_initialization[(NUM_NEURONS-1-i)*ADDR_W +: ADDR_W];
            for (int i = 0; i < NUM_NEURONS + 1; i++)
               ptr[i] <= connection_pointer_initialization[(NUM_NEURONS-i)*PTR_W +: PTR_W];
            for (int i = 0; i < MAX_CONN; i++)
               dconn[i] <= downstream_connections_initialization[(MAX_CONN-1-i)*ADDR_W +: ADDR_W];
         end

         case (state)
            ST_IDLE: begin
               if (clear && (work | snapshot) != '0) state <= ST_SCAN;
            end
            ST_SCAN: begin
               if (work == '0) begin
                  state <= (clear && snapshot != '0) ? ST_SCAN : ST_IDLE;
               end else if (scan_go) begin
                  state   <= ST_EMIT;
                  idx     <= scan_idx;
                  cur     <= scan_cur;
                  end_ptr <= scan_end;
               end
            end
            ST_EMIT: begin
               if (fifo_push) begin
                  if (cur == end_ptr - PTR_W'(1)) state <= ST_SCAN;
                  else                            cur   <= cur + PTR_W'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   spike_packet_fifo #(
      .WIDTH (2 * ADDR_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .CLK        (CLK),
      .RESET_N    (RESET_N),
      .push       (fifo_push),
      .push_data  (push_data),
      .pop        (fifo_pop),
      .head       (packet),
      .head_valid (packet_valid),
      .full       (fifo_full),
      .empty      (fifo_empty)
   );

endmodule
